seq_step_ctrl: RTL and testbench
================================

Name: seq_step_ctrl

Overview:
- Controller/checker for the team's 3-bit stepped sequence counter. Clears it, issues a programmed number of single-step enables with optional spacing and pause, and tracks the expected sequence in parallel.
- Compares the counter's state every cycle and reports pass/fail on a done pulse.
- Sits between the test/control logic and one counter instance; the counter holds its value unless step_en or cnt_rst is asserted.

Parameters:
- N_W, 8: width of step count and remaining-step counter.
- GAP, 0: idle cycles forced between consecutive step_en pulses; 0 means back-to-back.
- GAP_W, 4: width of the gap prescaler; GAP < 2**GAP_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a run; sampled only in IDLE
- num_steps  in  N_W  steps for this run; captured when start is accepted
- pause  in  1  level; freezes step issue and gap countdown
- cnt_q  in  3  counter state {C,B,A}; updates at the edge ending a step_en or cnt_rst cycle
- step_en  out  1  advance counter one step at next edge
- cnt_rst  out  1  force counter to 3'b000 at next edge
- busy  out  1  high in CLEAR, RUN, DONE
- done  out  1  one-cycle pulse, run finished
- pass  out  1  result of last run; valid with done, held until next accepted start
- steps_left  out  N_W  remaining steps to issue
- err_sticky  out  1  mismatch seen in current or last run

Behaviour:
- Single clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: state=IDLE, step_en=0, busy=0, done=0, pass=0, steps_left=0, err_sticky=0, gap_cnt=0, exp=3'b000.
- cnt_rst = rst OR (state==CLEAR). The counter is therefore cleared during reset too.
- Sequence from 3'b000 is fixed: 000→011→010→110→111→101→100→001→011…. It is a 7-state loop; 000 is entered only by clear.
- IDLE:
  - Leaves only on start=1: capture num_steps into steps_left, clear err_sticky and pass, go to CLEAR.
  - start while not in IDLE is ignored; no queuing.
- CLEAR (1 cycle): cnt_rst=1; exp←000; gap_cnt←0; go to RUN.
- RUN:
  - Issue a step when gap_cnt==0, pause==0 and steps_left!=0.
  - On a step: step_en=1 (combinational from state/counters), exp←seq_next(exp), steps_left−1, gap_cnt←GAP.
  - Otherwise, if gap_cnt!=0 and pause==0, gap_cnt−1.
  - Every RUN cycle compares cnt_q with exp (exp reflects all steps issued up to the previous edge).
  - Mismatch: err_sticky←1, pass←0, go to DONE immediately. The step_en of that cycle is suppressed.
  - steps_left==0, no mismatch: pass←1, go to DONE. The final step's result is thus checked one cycle after the last step_en.
  - pause: no step, gap frozen, compare continues.
- DONE (1 cycle): done=1, busy=1, pass valid; go to IDLE.
- num_steps=0: CLEAR→RUN (one compare against 000)→DONE, pass=1.
- rst mid-run: abort to IDLE on next edge with reset values; no done pulse.
- steps_left is not reloaded by start outside IDLE. No wrap: decrement only when nonzero.

Decomposition:
- Package seq_step_pkg:
  - state enum IDLE/CLEAR/RUN/DONE (2-bit);
  - SEQ_CLR=3'b000;
  - function seq_next(3-bit) implementing the loop above (001→011, 000→011 included).
- Sub-module seq_expect holds the 3-bit exp register with clear/advance inputs. The FSM, step counter and gap prescaler stay in seq_step_ctrl.

Test Plan:
- GAP=0, num_steps=3, start at cycle 0, model counter obeys step_en/cnt_rst:
  - cnt_rst=1 at cycle 1;
  - step_en=1 at cycles 2,3,4;
  - cnt_q 011,010,110 at cycles 3,4,5;
  - done=1, pass=1 at cycle 6;
  - busy low at cycle 7.
- num_steps=8 → step_en pulses follow exp 011,010,110,111,101,100,001,011 (wrap to 011); done with pass=1, err_sticky=0.
- Model counter sticks at 010 after the 2nd step, num_steps=5 → mismatch detected in cycle 5; err_sticky=1, done at cycle 6, pass=0, steps_left=2.
- GAP=2, num_steps=2, pause=1 for cycles 3–5 → step_en at cycles 2 and 8 only; done at cycle 10, pass=1.
- Edge cases:
  - num_steps=0 → done at cycle 3, pass=1, no step_en.
  - start pulsed during RUN → ignored, steps_left unchanged.
- rst=1 at cycle 3 of a 5-step run → cycle 4: state IDLE, busy=0, steps_left=0, cnt_rst=1 during rst, no done pulse.

Source files
------------

// File: rtl/seq_step_pkg.sv
// Shared types and the fixed 7-state stepping sequence of the team's 3-bit counter.
package seq_step_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Value the counter holds right after a clear; only reachable through clear.
  localparam logic [2:0] SEQ_CLR = 3'b000;

  // Next counter value after one step. 000 feeds into the loop at 011.
  function automatic logic [2:0] seq_next(input logic [2:0] s);
    logic [2:0] n;
    case (s)
      3'b000:  n = 3'b011;
      3'b011:  n = 3'b010;
      3'b010:  n = 3'b110;
      3'b110:  n = 3'b111;
      3'b111:  n = 3'b101;
      3'b101:  n = 3'b100;
      3'b100:  n = 3'b001;
      default: n = 3'b011;  // 001
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_step_ctrl_expect.sv
// Expected-value tracker: mirrors what the counter should hold given the
// clears and steps issued so far.
module seq_expect
  import seq_step_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       adv,
  output logic [2:0] exp_o
);

  logic [2:0] exp_d, exp_q;

  // Clear wins over advance; otherwise hold.
  always_comb begin
    exp_d = exp_q;
    if (clr)      exp_d = SEQ_CLR;
    else if (adv) exp_d = seq_next(exp_q);
  end

  // Expected-value register.
  always_ff @(posedge clk) begin
    if (rst) exp_q <= SEQ_CLR;
    else     exp_q <= exp_d;
  end

  assign exp_o = exp_q;

endmodule

// File: rtl/seq_step_ctrl.sv
// Drives one stepped sequence counter through a programmed run and checks
// its state every RUN cycle against an independently tracked expectation.
module seq_step_ctrl
  import seq_step_pkg::*;
#(
  parameter int N_W   = 8,
  parameter int GAP   = 0,
  parameter int GAP_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] num_steps,
  input  logic           pause,
  input  logic [2:0]     cnt_q,
  output logic           step_en,
  output logic           cnt_rst,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [N_W-1:0] steps_left,
  output logic           err_sticky
);

  state_e             state_d, state_q;
  logic [N_W-1:0]     steps_left_d, steps_left_q;
  logic [GAP_W-1:0]   gap_cnt_d, gap_cnt_q;
  logic               pass_d, pass_q;
  logic               err_d, err_q;
  logic               exp_clr, exp_adv;
  logic [2:0]         exp_val;
  logic               mismatch;

  seq_expect u_expect (
    .clk   (clk),
    .rst   (rst),
    .clr   (exp_clr),
    .adv   (exp_adv),
    .exp_o (exp_val)
  );

  assign mismatch = (cnt_q != exp_val);

  // Next-state, counters and step issue. A mismatch ends the run at once and
  // suppresses that cycle's step so the counter is left where it failed.
  always_comb begin
    state_d      = state_q;
    steps_left_d = steps_left_q;
    gap_cnt_d    = gap_cnt_q;
    pass_d       = pass_q;
    err_d        = err_q;
    step_en      = 1'b0;
    exp_clr      = 1'b0;
    exp_adv      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          steps_left_d = num_steps;
          err_d        = 1'b0;
          pass_d       = 1'b0;
          state_d      = CLEAR;
        end
      end
      CLEAR: begin
        exp_clr   = 1'b1;
        gap_cnt_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        if (mismatch) begin
          err_d   = 1'b1;
          pass_d  = 1'b0;
          state_d = DONE;
        end else if (steps_left_q == '0) begin
          // Last step's effect was compared this cycle.
          pass_d  = 1'b1;
          state_d = DONE;
        end else if (!pause) begin
          if (gap_cnt_q == '0) begin
            step_en      = 1'b1;
            exp_adv      = 1'b1;
            steps_left_d = steps_left_q - N_W'(1);
            gap_cnt_d    = GAP_W'(GAP);
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
      end
      default: state_d = IDLE;  // DONE lasts one cycle
    endcase
  end

  // State and run bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      steps_left_q <= '0;
      gap_cnt_q    <= '0;
      pass_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      steps_left_q <= steps_left_d;
      gap_cnt_q    <= gap_cnt_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
    end
  end

  // Counter is held clear while we are in reset as well.
  assign cnt_rst    = rst | (state_q == CLEAR);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign steps_left = steps_left_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Directed bench: two controllers (GAP=0 and GAP=2), each driving its own
// behavioural counter model; the GAP=0 model can be made to stick at 010.
module tb_seq_step_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] num_steps = 8'd0;
  logic       pause = 1'b0;
  logic       start0 = 1'b0, start2 = 1'b0;
  logic       stick0 = 1'b0;

  logic       step_en0, cnt_rst0, busy0, done0, pass0, err0;
  logic [7:0] left0;
  logic [2:0] cq0;
  logic       step_en2, cnt_rst2, busy2, done2, pass2, err2;
  logic [7:0] left2;
  logic [2:0] cq2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_step_ctrl #(.N_W(8), .GAP(0), .GAP_W(4)) u0 (
    .clk(clk), .rst(rst), .start(start0), .num_steps(num_steps), .pause(pause),
    .cnt_q(cq0), .step_en(step_en0), .cnt_rst(cnt_rst0), .busy(busy0),
    .done(done0), .pass(pass0), .steps_left(left0), .err_sticky(err0)
  );

  seq_step_ctrl #(.N_W(8), .GAP(2), .GAP_W(4)) u2 (
    .clk(clk), .rst(rst), .start(start2), .num_steps(num_steps), .pause(pause),
    .cnt_q(cq2), .step_en(step_en2), .cnt_rst(cnt_rst2), .busy(busy2),
    .done(done2), .pass(pass2), .steps_left(left2), .err_sticky(err2)
  );

  function automatic logic [2:0] mdl_next(input logic [2:0] s);
    logic [2:0] tbl [8];
    tbl = '{3'b011, 3'b011, 3'b110, 3'b010, 3'b001, 3'b100, 3'b111, 3'b101};
    return tbl[s];
  endfunction

  // Counter models: clear beats step; model 0 can stick at 010.
  always_ff @(posedge clk) begin
    if (cnt_rst0) cq0 <= 3'b000;
    else if (step_en0 && !(stick0 && cq0 == 3'b010)) cq0 <= mdl_next(cq0);
    if (cnt_rst2) cq2 <= 3'b000;
    else if (step_en2) cq2 <= mdl_next(cq2);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] seq8 [8];
  logic       gap_steps [10];

  initial begin
    seq8 = '{3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b001, 3'b011};
    gap_steps = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    tick(); tick();
    chk("rst_cnt_rst", 8'(cnt_rst0), 8'd1);
    chk("rst_busy", 8'(busy0), 8'd0);
    chk("rst_step_en", 8'(step_en0), 8'd0);
    rst = 1'b0;
    tick();
    chk("rst_done", 8'(done0), 8'd0);
    chk("rst_pass", 8'(pass0), 8'd0);
    chk("rst_left", left0, 8'd0);
    chk("rst_err", 8'(err0), 8'd0);
    chk("rst_cq", 8'(cq0), 8'd0);

    // GAP=0, 3 steps
    num_steps = 8'd3; start0 = 1'b1;
    tick(); start0 = 1'b0;                             // cycle 1
    chk("t1_c1_cnt_rst", 8'(cnt_rst0), 8'd1);
    chk("t1_c1_busy", 8'(busy0), 8'd1);
    chk("t1_c1_left", left0, 8'd3);
    tick(); chk("t1_c2_step", 8'(step_en0), 8'd1);     // cycle 2
    tick(); chk("t1_c3_step", 8'(step_en0), 8'd1);
    chk("t1_c3_cq", 8'(cq0), 8'h3);
    tick(); chk("t1_c4_step", 8'(step_en0), 8'd1);
    chk("t1_c4_cq", 8'(cq0), 8'h2);
    tick(); chk("t1_c5_step", 8'(step_en0), 8'd0);
    chk("t1_c5_cq", 8'(cq0), 8'h6);
    chk("t1_c5_done", 8'(done0), 8'd0);
    tick(); chk("t1_c6_done", 8'(done0), 8'd1);
    chk("t1_c6_pass", 8'(pass0), 8'd1);
    chk("t1_c6_busy", 8'(busy0), 8'd1);
    tick(); chk("t1_c7_busy", 8'(busy0), 8'd0);
    chk("t1_c7_done", 8'(done0), 8'd0);
    chk("t1_c7_pass_held", 8'(pass0), 8'd1);
    tick();

    // 8 steps with wrap to 011; start pulsed mid-run must be ignored
    num_steps = 8'd8; start0 = 1'b1;
    tick(); start0 = 1'b0;                             // cycle 1
    chk("t2_c1_pass_cleared", 8'(pass0), 8'd0);
    for (int k = 0; k < 8; k++) begin
      tick();                                          // cycle 2+k
      if (k == 2) start0 = 1'b1;
      if (k == 3) begin
        start0 = 1'b0;
        chk("t2_start_ignored_left", left0, 8'd5);
      end
      chk($sformatf("t2_step_%0d", k), 8'(step_en0), 8'd1);
      if (k > 0) chk($sformatf("t2_cq_%0d", k - 1), 8'(cq0), 8'(seq8[k - 1]));
    end
    tick();                                            // cycle 10
    chk("t2_c10_step", 8'(step_en0), 8'd0);
    chk("t2_c10_cq_wrap", 8'(cq0), 8'h3);
    tick();                                            // cycle 11
    chk("t2_done", 8'(done0), 8'd1);
    chk("t2_pass", 8'(pass0), 8'd1);
    chk("t2_err", 8'(err0), 8'd0);
    tick();
    chk("t2_idle", 8'(busy0), 8'd0);
    tick();

    // Counter sticks at 010 after second step
    stick0 = 1'b1; num_steps = 8'd5; start0 = 1'b1;
    tick(); start0 = 1'b0;                             // cycle 1
    tick(); tick(); tick();                            // cycle 4
    chk("t3_c4_step", 8'(step_en0), 8'd1);
    chk("t3_c4_cq", 8'(cq0), 8'h2);
    tick();                                            // cycle 5
    chk("t3_c5_step_suppr", 8'(step_en0), 8'd0);
    chk("t3_c5_cq_stuck", 8'(cq0), 8'h2);
    tick();                                            // cycle 6
    chk("t3_done", 8'(done0), 8'd1);
    chk("t3_pass", 8'(pass0), 8'd0);
    chk("t3_err", 8'(err0), 8'd1);
    chk("t3_left", left0, 8'd2);
    stick0 = 1'b0;
    tick();
    chk("t3_err_held", 8'(err0), 8'd1);
    tick();

    // GAP=2, 2 steps, pause over cycles 3..5
    num_steps = 8'd2; start2 = 1'b1;
    tick(); start2 = 1'b0;                             // cycle 1
    chk("t4_c1_cnt_rst", 8'(cnt_rst2), 8'd1);
    for (int c = 2; c < 10; c++) begin
      tick();
      pause = (c >= 3 && c <= 5);
      #1;
      chk($sformatf("t4_step_c%0d", c), 8'(step_en2), 8'(gap_steps[c]));
    end
    pause = 1'b0;
    chk("t4_c9_cq", 8'(cq2), 8'h2);
    tick();                                            // cycle 10
    chk("t4_done", 8'(done2), 8'd1);
    chk("t4_pass", 8'(pass2), 8'd1);
    tick(); tick();

    // num_steps = 0
    num_steps = 8'd0; start0 = 1'b1;
    tick(); start0 = 1'b0;                             // cycle 1
    tick();                                            // cycle 2
    chk("t5_c2_step", 8'(step_en0), 8'd0);
    chk("t5_c2_done", 8'(done0), 8'd0);
    tick();                                            // cycle 3
    chk("t5_done", 8'(done0), 8'd1);
    chk("t5_pass", 8'(pass0), 8'd1);
    tick(); tick();

    // Reset in the middle of a 5-step run
    num_steps = 8'd5; start0 = 1'b1;
    tick(); start0 = 1'b0;                             // cycle 1
    tick(); tick();                                    // cycle 3
    rst = 1'b1;
    #1;
    chk("t6_c3_cnt_rst", 8'(cnt_rst0), 8'd1);
    tick();                                            // cycle 4
    rst = 1'b0;
    #1;
    chk("t6_busy", 8'(busy0), 8'd0);
    chk("t6_left", left0, 8'd0);
    chk("t6_done", 8'(done0), 8'd0);
    chk("t6_cnt_rst_off", 8'(cnt_rst0), 8'd0);
    for (int c = 5; c < 9; c++) begin
      tick();
      chk($sformatf("t6_no_done_c%0d", c), 8'(done0 | busy0), 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
